mips_retire_monitor: RTL
========================

# mips_retire_monitor

Synthesizable retire monitor that sits beside `mips_single` and its successors. It decodes every retired instruction into an instruction class and keeps a saturating per-class retire counter. It also buffers a PC/class trace in a parametrised FIFO and raises a sticky halt request when a cycle budget expires. This replaces the bench-only decode/display/stop logic with hardware usable in simulation and on an FPGA.

## Interface
Parameters:
- `PC_W`, 32: width of the `pc` input and of `trace_pc`.
- `CNT_W`, 32: width of each per-class counter.
- `DEPTH`, 16: trace FIFO entries; power of two, minimum 2.
- `MAX_CYCLES`, 50: cycle budget counted after reset release; 0 disables the budget.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `retire_valid`, in, 1: an instruction retires this cycle.
- `pc`, in, `PC_W`: PC of the retiring instruction.
- `instr`, in, 32: instruction word of the retiring instruction.
- `cnt_en`, in, 1: recording enable; when low, counters and FIFO ignore retires.
- `clear`, in, 1: synchronous clear of counters, FIFO, overflow flag and drop count.
- `rd_sel`, in, 5: class index for counter readout.
- `rd_count`, out, `CNT_W`: registered count for `rd_sel`.
- `trace_valid`, out, 1: FIFO not empty.
- `trace_pc`, out, `PC_W`: PC field of the FIFO head entry.
- `trace_class`, out, 5: class field of the FIFO head entry.
- `trace_ready`, in, 1: consumer pops the head entry when `trace_valid` is also high.
- `overflow`, out, 1: sticky; at least one trace entry has been dropped.
- `drop_count`, out, 16: number of dropped entries; saturates at 0xFFFF.
- `halt`, out, 1: sticky; the cycle budget has expired.

## Operation
- **Class decode (combinational)**:
  - `instr == 0` → NOP (0).
  - opcode 0 with funct 32/34/36/37/42/2/0/24/16/18 → ADD 1, SUB 2, AND 3, OR 4, SLT 5, SRL 6, SLL 7, MULT 8, MFHI 9, MFLO 10.
  - opcode 35/43/4/2/9/7/13 → LW 11, SW 12, BEQ 13, J 14, ADDIU 15, BGTZ 16, ORI 17.
  - Anything else → UNKNOWN 18.
  - `rd_sel` values above 18 read as 0.
- **Recording**: a retire is recorded when `retire_valid && cnt_en && !halt && !clear`.
- **Counters**: each recorded retire increments the counter for its class by 1. A counter at `2^CNT_W-1` holds its value.
- **Trace push**: each recorded retire pushes {pc, class}.
  - Full FIFO with no pop in the same cycle: the entry is dropped, `overflow` is set, and `drop_count` increments.
  - Full FIFO with a pop in the same cycle: the push is accepted and nothing is dropped.
- **Pop**: `trace_valid && trace_ready` removes the head. Pointers wrap modulo `DEPTH`, and an occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
- **Cycle budget**:
  - The cycle counter increments every cycle after reset, independent of `cnt_en` and `clear`.
  - When the count reaches `MAX_CYCLES`, `halt` goes high and stays high until `rst`.
  - While `halt` is high, nothing is recorded, but the FIFO can still be drained.
- **`clear` priority**: `clear` has priority over a simultaneous retire and pop. At the next edge counters = 0, FIFO empty, `overflow` = 0, `drop_count` = 0. `clear` does not affect `halt` or the cycle counter.
- **Reset**: all counters 0, FIFO empty, cycle counter 0. Every output is 0 at reset: `rd_count`, `trace_valid`, `trace_pc`, `trace_class`, `overflow`, `drop_count`, `halt`.

## Timing
- A counter update is visible through `rd_count` two edges after the retire: one edge for the counter update, one for the registered readout.
- `rd_count` reflects `rd_sel` with 1-cycle latency.
- A pushed entry appears on `trace_valid`/`trace_pc`/`trace_class` one edge after the push (show-ahead head, no extra read latency). This also applies when the FIFO was empty; there is no bypass.
- `halt` rises on the edge at which the cycle counter reaches `MAX_CYCLES`. The retire sampled at that same edge is still recorded.
- Reset mid-operation discards all state at the next edge, including FIFO contents.

## Structure
- **Package `mips_trace_pkg`**:
  - opcode and funct constants;
  - class codes 0–18;
  - `NUM_CLASSES = 19`;
  - trace entry typedef {pc, class}.
- **Sub-module `trace_fifo`**: parametrised synchronous FIFO with push/pop, full/empty, drop-on-full and sticky overflow. It is instantiated once.
- **Top level**: decode, counters, readout register and cycle budget stay in the top.

## Test plan
- Retire `add` (0x012A4020), then `lw` (0x8D090004), then 0x00000000; `rd_sel` = 1, 11, 0 → `rd_count` = 1 each.
- Push 17 retires into `DEPTH` = 16 with `trace_ready` = 0 → `overflow` = 1, `drop_count` = 1, and 16 entries drain in PC order.
- Full FIFO with push and pop in the same cycle → occupancy stays 16, `drop_count` unchanged.
- `MAX_CYCLES` = 50 with continuous retires → `halt` = 1 at cycle 50, and all counters stop afterwards.
- `clear` asserted together with a retire → all counters 0 and `trace_valid` = 0 on the next cycle; the retire is not recorded.
- Preload a counter to 0xFFFFFFFF (`CNT_W` = 32) and retire one more instruction of that class → the counter stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/mips_trace_pkg.sv
// Shared definitions for the MIPS retire monitor.
//   - opcode / funct field constants for the decoded instruction subset
//   - instruction class codes 0..18 and NUM_CLASSES
//   - trace entry layout {pc, class} for the default 32-bit PC
//   - decode_class(): maps a 32-bit instruction word to its class
package mips_trace_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_BGTZ  = 6'd7;
  localparam logic [5:0] OP_ORI   = 6'd13;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_MULT = 6'd24;
  localparam logic [5:0] FN_MFHI = 6'd16;
  localparam logic [5:0] FN_MFLO = 6'd18;

  localparam int NUM_CLASSES = 19;
  localparam int CLASS_W     = 5;

  typedef enum logic [CLASS_W-1:0] {
    CLS_NOP     = 5'd0,
    CLS_ADD     = 5'd1,
    CLS_SUB     = 5'd2,
    CLS_AND     = 5'd3,
    CLS_OR      = 5'd4,
    CLS_SLT     = 5'd5,
    CLS_SRL     = 5'd6,
    CLS_SLL     = 5'd7,
    CLS_MULT    = 5'd8,
    CLS_MFHI    = 5'd9,
    CLS_MFLO    = 5'd10,
    CLS_LW      = 5'd11,
    CLS_SW      = 5'd12,
    CLS_BEQ     = 5'd13,
    CLS_J       = 5'd14,
    CLS_ADDIU   = 5'd15,
    CLS_BGTZ    = 5'd16,
    CLS_ORI     = 5'd17,
    CLS_UNKNOWN = 5'd18
  } class_e;

  // Trace entry as seen by a consumer of a 32-bit-PC monitor.
  typedef struct packed {
    logic [31:0] pc;
    class_e      cls;
  } trace_entry_t;

  // The all-zero word is checked first: it is also "sll $0,$0,0" and must
  // be classified as NOP rather than SLL.
  function automatic class_e decode_class(input logic [31:0] instr);
    class_e c;
    c = CLS_UNKNOWN;
    if (instr == 32'd0) begin
      c = CLS_NOP;
    end else if (instr[31:26] == OP_RTYPE) begin
      case (instr[5:0])
        FN_ADD:  c = CLS_ADD;
        FN_SUB:  c = CLS_SUB;
        FN_AND:  c = CLS_AND;
        FN_OR:   c = CLS_OR;
        FN_SLT:  c = CLS_SLT;
        FN_SRL:  c = CLS_SRL;
        FN_SLL:  c = CLS_SLL;
        FN_MULT: c = CLS_MULT;
        FN_MFHI: c = CLS_MFHI;
        FN_MFLO: c = CLS_MFLO;
        default: c = CLS_UNKNOWN;
      endcase
    end else begin
      case (instr[31:26])
        OP_LW:    c = CLS_LW;
        OP_SW:    c = CLS_SW;
        OP_BEQ:   c = CLS_BEQ;
        OP_J:     c = CLS_J;
        OP_ADDIU: c = CLS_ADDIU;
        OP_BGTZ:  c = CLS_BGTZ;
        OP_ORI:   c = CLS_ORI;
        default:  c = CLS_UNKNOWN;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO for retire trace entries.
// A push into a full FIFO is dropped unless a pop happens in the same cycle;
// drops set a sticky overflow flag and bump a saturating 16-bit drop count.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           synchronous flush of contents, overflow and drop count
//   push, push_data write request and entry
//   pop             remove head (ignored when empty)
//   valid, head     FIFO not empty / head entry (zero while empty)
//   overflow        sticky: at least one entry dropped
//   drop_count      number of dropped entries, saturating at 0xFFFF
module trace_fifo #(
  parameter int DATA_W = 37,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  // One bit wider than the pointers so that full and empty are distinct.
  logic [AW:0]       occ;

  logic full, empty, do_push, do_pop, drop;

  assign full    = (occ == OCC_FULL);
  assign empty   = (occ == '0);
  assign do_pop  = pop && !empty && !clear;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && !clear && (!full || do_pop);
  assign drop    = push && !clear && full && !do_pop;

  // NOTE: the storage array has no reset; occupancy and pointers define what
  // is valid, and leaving the RAM unreset lets it map onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign valid = !empty;
  // Gate the head so stale RAM contents never appear on the outputs.
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mips_retire_monitor.sv
// Retire monitor for mips_single and successors.
// Decodes each retired instruction into a class, keeps saturating per-class
// counters, buffers a {pc, class} trace and raises a sticky halt when the
// cycle budget after reset expires.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   retire_valid, pc, instr   retiring instruction
//   cnt_en                    recording enable
//   clear                     flush counters, trace FIFO, overflow, drop count
//   rd_sel / rd_count         class select / registered counter readout
//   trace_valid, trace_pc,
//   trace_class, trace_ready  trace FIFO head and pop handshake
//   overflow, drop_count      trace drop status
//   halt                      sticky cycle-budget-expired flag
module mips_retire_monitor
  import mips_trace_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int CNT_W      = 32,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_valid,
  input  logic [PC_W-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic             cnt_en,
  input  logic             clear,
  input  logic [4:0]       rd_sel,
  output logic [CNT_W-1:0] rd_count,
  output logic             trace_valid,
  output logic [PC_W-1:0]  trace_pc,
  output logic [4:0]       trace_class,
  input  logic             trace_ready,
  output logic             overflow,
  output logic [15:0]      drop_count,
  output logic             halt
);

  localparam int ENTRY_W = PC_W + CLASS_W;
  localparam int CYC_W   = (MAX_CYCLES < 2) ? 2 : $clog2(MAX_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES);

  class_e             cls;
  logic               record;
  logic [CNT_W-1:0]   cnt_q [NUM_CLASSES];
  logic [CYC_W-1:0]   cyc_q;
  logic [ENTRY_W-1:0] head;
  logic               trace_pop;

  assign cls    = decode_class(instr);
  // clear wins over a simultaneous retire; a halted monitor records nothing.
  assign record = retire_valid && cnt_en && !halt && !clear;

  // NOTE: all sequential state is written with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
    end else if (record && (cnt_q[cls] != '1)) begin
      cnt_q[cls] <= cnt_q[cls] + CNT_W'(1);
    end
  end

  // Readout register: one edge after the counter itself updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
    end else if (rd_sel < CLASS_W'(NUM_CLASSES)) begin
      rd_count <= cnt_q[rd_sel];
    end else begin
      rd_count <= '0;
    end
  end

  // Cycle budget. The counter freezes once halted, so it never wraps back
  // onto the limit; with MAX_CYCLES == 0 it free-runs and halt stays low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      halt  <= 1'b0;
    end else if (!halt) begin
      cyc_q <= cyc_q + CYC_W'(1);
      if ((MAX_CYCLES != 0) && (cyc_q + CYC_W'(1) == CYC_LIMIT)) halt <= 1'b1;
    end
  end

  // Draining stays possible while halted; only recording stops.
  assign trace_pop = trace_valid && trace_ready;

  trace_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_trace_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .push       (record),
    .push_data  ({pc, cls}),
    .pop        (trace_pop),
    .valid      (trace_valid),
    .head       (head),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  assign trace_pc    = head[ENTRY_W-1:CLASS_W];
  assign trace_class = head[CLASS_W-1:0];

endmodule
